// File: rtl/fft_bitrev_reorder_pkg.sv
// Shared FFT definitions: the fixed-point sample type, the default frame size
// and the bit-reversal helper used by the natural-order reorder buffer.
package fft_bitrev_reorder_pkg;

  localparam int FIXED_POINT_WIDTH = 16;
  localparam int FIXED_POINT_FRAC  = 15;
  localparam int PRODUCT_WIDTH     = 2 * FIXED_POINT_WIDTH;

  localparam int N_FFT        = 64;
  localparam int BITREV_MAX_W = 10;

  typedef struct packed {
    logic signed [PRODUCT_WIDTH-1:0] r;
    logic signed [PRODUCT_WIDTH-1:0] i;
  } complex_product_t;

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_DRAIN = 1'b1
  } rd_state_e;

  // Reverses the low 'width' bits of idx; bits above 'width' come back as zero.
  function automatic logic [BITREV_MAX_W-1:0] bitrev(input logic [BITREV_MAX_W-1:0] idx,
                                                     input int width);
    logic [BITREV_MAX_W-1:0] rev;
    rev = '0;
    for (int b = 0; b < BITREV_MAX_W; b++) begin
      if (b < width) begin
        rev[b] = idx[width-1-b];
      end
    end
    return rev;
  endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One frame of storage: N complex samples, synchronous write, asynchronous read.
module fft_reorder_bank
  import fft_bitrev_reorder_pkg::*;
#(
  parameter int N     = N_FFT,
  parameter int LOG2N = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 weI,
  input  logic [LOG2N-1:0]     waddrI,
  input  complex_product_t     wdataI,
  input  logic [LOG2N-1:0]     raddrI,
  output complex_product_t     rdataO
);

  complex_product_t mem [N];

  // Store one sample per accepted write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (weI) begin
      mem[waddrI] <= wdataI;
    end
  end

  assign rdataO = mem[raddrI];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Converts bit-reversed FFT output frames to natural order using two ping-pong
// banks: one frame is written at bit-reversed addresses while the other is
// read out sequentially on a valid/ready stream.
module fft_bitrev_reorder
  import fft_bitrev_reorder_pkg::*;
#(
  parameter int N = N_FFT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  complex_product_t        in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output complex_product_t        out_data,
  output logic [$clog2(N)-1:0]    out_index,
  output logic                    out_last,
  output logic                    overflow
);

  localparam int LOG2N = $clog2(N);
  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

  rd_state_e        state_q,    state_d;
  logic [1:0]       full_q,     full_d;
  logic             wrBank_q,   wrBank_d;
  logic [LOG2N-1:0] wrCnt_q,    wrCnt_d;
  logic             rdBank_q,   rdBank_d;
  logic [LOG2N-1:0] rdCnt_q,    rdCnt_d;
  logic             overflow_q, overflow_d;

  logic             wrAccept;
  logic             rdFire;
  logic             we0;
  logic             we1;
  logic [LOG2N-1:0] wrAddr;
  complex_product_t rdData0;
  complex_product_t rdData1;

  assign wrAddr = LOG2N'(bitrev(BITREV_MAX_W'(wrCnt_q), LOG2N));

  fft_reorder_bank #(.N(N), .LOG2N(LOG2N)) u_bank0 (
    .clk    (clk),
    .weI    (we0),
    .waddrI (wrAddr),
    .wdataI (in_data),
    .raddrI (rdCnt_q),
    .rdataO (rdData0)
  );

  fft_reorder_bank #(.N(N), .LOG2N(LOG2N)) u_bank1 (
    .clk    (clk),
    .weI    (we1),
    .waddrI (wrAddr),
    .wdataI (in_data),
    .raddrI (rdCnt_q),
    .rdataO (rdData1)
  );

  // Next-state for both pointers, the bank-full flags and the drain FSM; the FSM
  // looks at the updated flags so a frame completing now is readable next cycle.
  always_comb begin
    full_d     = full_q;
    wrBank_d   = wrBank_q;
    wrCnt_d    = wrCnt_q;
    rdBank_d   = rdBank_q;
    rdCnt_d    = rdCnt_q;
    overflow_d = overflow_q;
    we0        = 1'b0;
    we1        = 1'b0;

    wrAccept = in_valid && !full_q[wrBank_q];
    rdFire   = (state_q == RD_DRAIN) && out_ready;

    if (in_valid && full_q[wrBank_q]) begin
      overflow_d = 1'b1;
    end

    if (wrAccept) begin
      we0 = !wrBank_q;
      we1 = wrBank_q;
      if (wrCnt_q == LAST_IDX) begin
        full_d[wrBank_q] = 1'b1;
        wrBank_d         = !wrBank_q;
        wrCnt_d          = '0;
      end else begin
        wrCnt_d = wrCnt_q + LOG2N'(1);
      end
    end

    if (rdFire) begin
      if (rdCnt_q == LAST_IDX) begin
        full_d[rdBank_q] = 1'b0;
        rdBank_d         = !rdBank_q;
        rdCnt_d          = '0;
      end else begin
        rdCnt_d = rdCnt_q + LOG2N'(1);
      end
    end

    state_d = full_d[rdBank_d] ? RD_DRAIN : RD_IDLE;
  end

  // Register all pointer, flag and FSM state; reset discards any partial or
  // undrained frames.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RD_IDLE;
      full_q     <= '0;
      wrBank_q   <= 1'b0;
      wrCnt_q    <= '0;
      rdBank_q   <= 1'b0;
      rdCnt_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      full_q     <= full_d;
      wrBank_q   <= wrBank_d;
      wrCnt_q    <= wrCnt_d;
      rdBank_q   <= rdBank_d;
      rdCnt_q    <= rdCnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign out_valid = (state_q == RD_DRAIN);
  assign out_data  = rdBank_q ? rdData1 : rdData0;
  assign out_index = rdCnt_q;
  assign out_last  = out_valid && (rdCnt_q == LAST_IDX);
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Bench for the bit-reversal reorder buffer at N=8: a frame-queue model predicts
// every output cycle, and directed scenarios pin the model with literal values.
module tb_fft_bitrev_reorder;
  import fft_bitrev_reorder_pkg::*;

  localparam int N     = 8;
  localparam int LOG2N = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  complex_product_t in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  complex_product_t out_data;
  logic [LOG2N-1:0] out_index;
  logic             out_last;
  logic             overflow;

  fft_bitrev_reorder #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int readyMode = 0;
  bit modelReady = 0;

  complex_product_t mDone[$];
  complex_product_t mPart[$];
  int mRdPos = 0;
  bit mOverflow = 0;

  int capR[$];
  int capI[$];
  int capCycle[$];

  function automatic int revIdx(int k);
    int x;
    int rev;
    x = k;
    rev = 0;
    for (int b = 0; b < LOG2N; b++) begin
      rev = rev * 2 + (x % 2);
      x = x / 2;
    end
    return rev;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cycle);
    end
  endtask

  // Model: completed frames queue up (at most two in flight), reads pop the head frame.
  always @(posedge clk) begin
    bit bothFull;
    cycle++;
    if (reset) begin
      mDone.delete();
      mPart.delete();
      mRdPos = 0;
      mOverflow = 0;
      modelReady = 1;
    end else begin
      bothFull = (mDone.size() / N) == 2;
      if (mDone.size() > 0 && out_ready) begin
        mRdPos++;
        if (mRdPos == N) begin
          for (int k = 0; k < N; k++) void'(mDone.pop_front());
          mRdPos = 0;
        end
      end
      if (in_valid) begin
        if (bothFull) begin
          mOverflow = 1;
        end else begin
          mPart.push_back(in_data);
          if (mPart.size() == N) begin
            foreach (mPart[k]) mDone.push_back(mPart[k]);
            mPart.delete();
          end
        end
      end
    end
  end

  // Ready pattern driver: always ready, 1-0-0 pattern, or stalled.
  always @(posedge clk) begin
    #1;
    case (readyMode)
      1:       out_ready = (cycle % 3 == 0);
      2:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  end

  // Compare DUT outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (modelReady) begin
      checkOutput("out_valid", 64'(out_valid), 64'(mDone.size() > 0));
      checkOutput("overflow", 64'(overflow), 64'(mOverflow));
      if (mDone.size() > 0 && out_valid === 1'b1) begin
        checkOutput("out_index", 64'(out_index), 64'(mRdPos));
        checkOutput("out_last", 64'(out_last), 64'(mRdPos == N - 1));
        checkOutput("out_data", 64'(out_data), 64'(mDone[revIdx(mRdPos)]));
        if (out_ready) begin
          capR.push_back(int'(out_data.r));
          capI.push_back(int'(out_data.i));
          capCycle.push_back(cycle);
        end
      end else begin
        checkOutput("out_last_idle", 64'(out_last), 64'(0));
      end
    end
  end

  task automatic applyStimulus(input int tag, input bit gaps, input int count);
    int k;
    k = 0;
    while (k < count) begin
      @(posedge clk);
      #1;
      if (gaps && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data.r = PRODUCT_WIDTH'(k);
        in_data.i = PRODUCT_WIDTH'(tag);
        k++;
      end
    end
  endtask

  task automatic stopInput();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while ((mDone.size() != 0 || mPart.size() != 0) && n < 300) begin
      @(posedge clk);
      n++;
    end
    checkOutput("drain_timeout", 64'(n < 300), 64'(1));
    repeat (2) @(posedge clk);
  endtask

  task automatic checkNaturalOrder(input string name);
    int expR[8];
    expR = '{0, 4, 2, 6, 1, 5, 3, 7};
    checkOutput({name, "_count"}, 64'(capR.size()), 64'(8));
    for (int j = 0; j < 8 && j < capR.size(); j++) begin
      checkOutput({name, "_seq"}, 64'(capR[j]), 64'(expR[j]));
    end
  endtask

  initial begin
    // Single frame, always ready.
    readyMode = 0;
    doReset();
    capR.delete(); capI.delete(); capCycle.delete();
    applyStimulus(1, 0, N);
    stopInput();
    waitIdle();
    checkNaturalOrder("basic");

    // Single frame, stalling downstream.
    doReset();
    readyMode = 1;
    capR.delete(); capI.delete(); capCycle.delete();
    applyStimulus(2, 0, N);
    stopInput();
    waitIdle();
    checkNaturalOrder("stall");
    readyMode = 0;

    // Three back-to-back frames: output must be gapless.
    doReset();
    capR.delete(); capI.delete(); capCycle.delete();
    applyStimulus(1, 0, N);
    applyStimulus(2, 0, N);
    applyStimulus(3, 0, N);
    stopInput();
    waitIdle();
    checkOutput("b2b_count", 64'(capR.size()), 64'(24));
    if (capCycle.size() == 24) begin
      checkOutput("b2b_nobubble", 64'(capCycle[23] - capCycle[0]), 64'(23));
      checkOutput("b2b_frame3_tag", 64'(capI[16]), 64'(3));
    end
    checkOutput("b2b_overflow", 64'(overflow), 64'(0));

    // Stalled downstream: third frame dropped, overflow sticks.
    doReset();
    readyMode = 2;
    capR.delete(); capI.delete(); capCycle.delete();
    applyStimulus(1, 0, N);
    applyStimulus(2, 0, N);
    applyStimulus(3, 0, N);
    stopInput();
    @(negedge clk);
    checkOutput("ovf_set", 64'(overflow), 64'(1));
    readyMode = 0;
    waitIdle();
    checkOutput("ovf_count", 64'(capR.size()), 64'(16));
    if (capI.size() == 16) begin
      checkOutput("ovf_first_tag", 64'(capI[0]), 64'(1));
      checkOutput("ovf_second_tag", 64'(capI[15]), 64'(2));
    end
    checkOutput("ovf_sticky", 64'(overflow), 64'(1));

    // Reset mid-frame, then a fresh frame.
    doReset();
    capR.delete(); capI.delete(); capCycle.delete();
    applyStimulus(4, 0, 5);
    doReset();
    @(negedge clk);
    checkOutput("rst_valid", 64'(out_valid), 64'(0));
    applyStimulus(5, 0, N);
    stopInput();
    waitIdle();
    checkNaturalOrder("midrst");
    if (capI.size() > 0) checkOutput("midrst_tag", 64'(capI[0]), 64'(5));

    // Random input gaps.
    doReset();
    capR.delete(); capI.delete(); capCycle.delete();
    applyStimulus(6, 1, N);
    stopInput();
    waitIdle();
    checkNaturalOrder("gaps");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
